// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO latch sequencer: FSM states,
// Johnson step codes and the step-to-strobe decode.
package siso_pkg;

   localparam int NSTAGES = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [3:0] J_STEP0 = 4'b0000;
   localparam logic [3:0] J_STEP1 = 4'b0001;
   localparam logic [3:0] J_STEP2 = 4'b0011;
   localparam logic [3:0] J_STEP3 = 4'b0111;
   localparam logic [3:0] J_STEP4 = 4'b1111;
   localparam logic [3:0] J_STEP5 = 4'b1110;
   localparam logic [3:0] J_STEP6 = 4'b1100;
   localparam logic [3:0] J_STEP7 = 4'b1000;

   function automatic logic [3:0] johnson_next(input logic [3:0] j);
      return {j[2:0], ~j[3]};
   endfunction

   function automatic logic [NSTAGES-1:0] johnson_decode(input logic [3:0] j);
      logic [NSTAGES-1:0] oh;
      oh = 8'h00;
      case (j)
         J_STEP0: oh = 8'h01;
         J_STEP1: oh = 8'h02;
         J_STEP2: oh = 8'h04;
         J_STEP3: oh = 8'h08;
         J_STEP4: oh = 8'h10;
         J_STEP5: oh = 8'h20;
         J_STEP6: oh = 8'h40;
         J_STEP7: oh = 8'h80;
         default: oh = 8'h00;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/johnson4.sv
// 4-bit Johnson phase counter with a registered one-hot strobe decode.
// EN from a cleared state starts at step 0; EN while active advances one step.
import siso_pkg::*;

module johnson4 (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               EN,
   input  logic               CLR,
   output logic [3:0]         JOHNSON,
   output logic [NSTAGES-1:0] ONEHOT
);

   logic [3:0]         johnson_q, johnson_d;
   logic [NSTAGES-1:0] onehot_q, onehot_d;

   // Next phase and strobe; a zero strobe marks the counter as parked
   always_comb begin
      johnson_d = johnson_q;
      onehot_d  = onehot_q;
      if (CLR) begin
         johnson_d = J_STEP0;
         onehot_d  = 8'h00;
      end else if (EN) begin
         if (onehot_q != 8'h00) begin
            johnson_d = johnson_next(johnson_q);
         end else begin
            johnson_d = J_STEP0;
         end
         onehot_d = johnson_decode(johnson_d);
      end else begin
         johnson_d = johnson_q;
         onehot_d  = onehot_q;
      end
   end

   // Phase and strobe registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         johnson_q <= 4'b0000;
         onehot_q  <= 8'h00;
      end else begin
         johnson_q <= johnson_d;
         onehot_q  <= onehot_d;
      end
   end

   assign JOHNSON = johnson_q;
   assign ONEHOT  = onehot_q;

endmodule

// File: rtl/siso_seq.sv
// SISO latch-strobe sequencer: IDLE/RUN/DRAIN control around a Johnson counter.
// Optional bounded bursts are compiled in with SISO_SEQ_BURST_EN.
import siso_pkg::*;

module siso_seq (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       STOP,
   input  logic       SHOW_LFSR,
   input  logic [7:0] LFSR_STATE,
   input  logic [7:0] BURST_LEN,
   output logic [3:0] JOHNSON,
   output logic [7:0] PULSES,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] BYTE_OUT
);

   state_e     state_q, state_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       at_step7;
   logic       burst_end;
   logic       j_clr;
   logic       j_en;
   logic [3:0] johnson_s;
   logic [7:0] pulses_s;

   assign at_step7 = (state_q != IDLE) && (johnson_s == J_STEP7);

`ifdef SISO_SEQ_BURST_EN
   logic [7:0] round_q, round_d;
   logic [7:0] burst_q, burst_d;

   assign burst_end = at_step7 && (burst_q != 8'd0) && ((round_q + 8'd1) == burst_q);

   // Latch the burst length at run start and count completed rounds
   always_comb begin
      round_d = round_q;
      burst_d = burst_q;
      if (state_q == IDLE) begin
         if (state_d == RUN) begin
            round_d = 8'd0;
            burst_d = BURST_LEN;
         end else begin
            round_d = round_q;
            burst_d = burst_q;
         end
      end else if (at_step7) begin
         round_d = round_q + 8'd1;
      end else begin
         round_d = round_q;
      end
   end

   // Burst registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         round_q <= 8'd0;
         burst_q <= 8'd0;
      end else begin
         round_q <= round_d;
         burst_q <= burst_d;
      end
   end
`else
   logic unused_burst_len;
   assign unused_burst_len = ^BURST_LEN;
   assign burst_end        = 1'b0;
`endif

   // Next state; a stop at step 7 exits at once so no partial round is emitted
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (START && !STOP) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (STOP) begin
               state_d = at_step7 ? IDLE : DRAIN;
            end else if (burst_end) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (at_step7) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q != IDLE) && (state_d == IDLE);
      j_clr  = (state_d == IDLE);
      j_en   = !j_clr;
   end

   // State and status registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   johnson4 u_johnson (
      .CLK     (CLK),
      .RESET   (RESET),
      .EN      (j_en),
      .CLR     (j_clr),
      .JOHNSON (johnson_s),
      .ONEHOT  (pulses_s)
   );

   assign JOHNSON  = johnson_s;
   assign PULSES   = pulses_s;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign BYTE_OUT = SHOW_LFSR ? LFSR_STATE : pulses_s;

endmodule

// File: tb/tb_siso_seq.sv
// Self-checking bench for siso_seq: vector table plus burst/unbounded run sequences.
module tb_siso_seq;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b1;
   logic       STOP = 1'b0;
   logic       SHOW_LFSR = 1'b0;
   logic [7:0] LFSR_STATE = 8'h00;
   logic [7:0] BURST_LEN = 8'h00;
   logic [3:0] JOHNSON;
   logic [7:0] PULSES;
   logic       BUSY;
   logic       DONE;
   logic [7:0] BYTE_OUT;

   siso_seq dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .STOP       (STOP),
      .SHOW_LFSR  (SHOW_LFSR),
      .LFSR_STATE (LFSR_STATE),
      .BURST_LEN  (BURST_LEN),
      .JOHNSON    (JOHNSON),
      .PULSES     (PULSES),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .BYTE_OUT   (BYTE_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       r;
      logic       s;
      logic       p;
      logic       sh;
      logic [7:0] lf;
      logic [7:0] bl;
      logic [3:0] ej;
      logic [7:0] ep;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   vec_no = 0;
   logic [3:0] jtab [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s vec %0d: got %h expected %h", name, vec_no, act, exp);
   endtask

   // drive one cycle of inputs, expect the registered result after the edge
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge CLK);
      RESET = v.r; START = v.s; STOP = v.p; SHOW_LFSR = v.sh;
      LFSR_STATE = v.lf; BURST_LEN = v.bl;
      exp_q.push_back(v);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk("JOHNSON", {4'h0, JOHNSON}, {4'h0, e.ej});
      chk("PULSES", PULSES, e.ep);
      chk("BUSY", {7'h00, BUSY}, {7'h00, e.eb});
      chk("DONE", {7'h00, DONE}, {7'h00, e.ed});
      chk("BYTE_OUT", BYTE_OUT, e.sh ? e.lf : e.ep);
      vec_no++;
   endtask

   function automatic void addv(input logic r, s, p, sh, input logic [7:0] lf,
                                input logic [3:0] ej, input logic [7:0] ep, input logic eb, ed);
      vecs.push_back('{r, s, p, sh, lf, 8'h00, ej, ep, eb, ed});
   endfunction

   // START at index 0 expects step 0, then steps i%8 with BURST_LEN switching at change_at
   task automatic run_steps(input logic [7:0] bl0, input logic [7:0] bl1, input int change_at, input int n);
      logic [7:0] one;
      one = 8'h01;
      for (int i = 0; i < n; i++) begin
         apply('{1'b0, (i == 0), 1'b0, 1'b0, 8'h00, (i >= change_at) ? bl1 : bl0,
                 jtab[i % 8], one << (i % 8), 1'b1, 1'b0});
      end
   endtask

   initial begin
      // reset held with START high, then run
      addv(1,1,0,0,8'h00, 4'h0,8'h00,0,0);
      addv(1,1,0,0,8'h00, 4'h0,8'h00,0,0);
      addv(0,1,0,0,8'h00, 4'h0,8'h01,1,0);
      addv(0,1,0,0,8'h00, 4'h1,8'h02,1,0);
      addv(0,0,0,1,8'hA5, 4'h3,8'h04,1,0);
      addv(0,0,0,0,8'hA5, 4'h7,8'h08,1,0);
      addv(0,0,0,0,8'h00, 4'hF,8'h10,1,0);
      addv(0,0,0,1,8'h3C, 4'hE,8'h20,1,0);
      addv(0,0,0,0,8'h00, 4'hC,8'h40,1,0);
      addv(0,0,0,0,8'h00, 4'h8,8'h80,1,0);
      addv(0,0,0,0,8'h00, 4'h0,8'h01,1,0);
      addv(0,0,0,0,8'h00, 4'h1,8'h02,1,0);
      addv(0,0,0,0,8'h00, 4'h3,8'h04,1,0);
      addv(0,0,0,0,8'h00, 4'h7,8'h08,1,0);
      // STOP at step 3: drain through step 7, STOP/START ignored meanwhile
      addv(0,0,1,0,8'h00, 4'hF,8'h10,1,0);
      addv(0,0,1,0,8'h00, 4'hE,8'h20,1,0);
      addv(0,1,0,0,8'h00, 4'hC,8'h40,1,0);
      addv(0,0,0,0,8'h00, 4'h8,8'h80,1,0);
      addv(0,0,0,0,8'h00, 4'h0,8'h00,0,1);
      addv(0,0,0,0,8'h00, 4'h0,8'h00,0,0);
      // START and STOP together in IDLE: STOP wins
      addv(0,1,1,0,8'h00, 4'h0,8'h00,0,0);
      addv(0,1,1,1,8'hA5, 4'h0,8'h00,0,0);
      addv(0,1,0,0,8'h00, 4'h0,8'h01,1,0);
      addv(0,0,0,0,8'h00, 4'h1,8'h02,1,0);
      addv(0,0,0,0,8'h00, 4'h3,8'h04,1,0);
      addv(0,0,0,0,8'h00, 4'h7,8'h08,1,0);
      addv(0,0,0,0,8'h00, 4'hF,8'h10,1,0);
      addv(0,0,0,0,8'h00, 4'hE,8'h20,1,0);
      addv(0,0,0,0,8'h00, 4'hC,8'h40,1,0);
      addv(0,0,0,0,8'h00, 4'h8,8'h80,1,0);
      // STOP at step 7: immediate IDLE
      addv(0,0,1,0,8'h00, 4'h0,8'h00,0,1);
      addv(0,0,1,0,8'h00, 4'h0,8'h00,0,0);
      addv(0,1,0,0,8'h00, 4'h0,8'h01,1,0);
      addv(0,0,0,0,8'h00, 4'h1,8'h02,1,0);
      addv(0,0,0,0,8'h00, 4'h3,8'h04,1,0);
      addv(0,0,0,0,8'h00, 4'h7,8'h08,1,0);
      addv(0,0,0,0,8'h00, 4'hF,8'h10,1,0);
      addv(0,0,0,0,8'h00, 4'hE,8'h20,1,0);
      // RESET at step 5 with START high: IDLE, and no DONE after release
      addv(1,1,0,0,8'h00, 4'h0,8'h00,0,0);
      addv(0,0,0,0,8'h00, 4'h0,8'h00,0,0);

      foreach (vecs[i]) apply(vecs[i]);

`ifdef SISO_SEQ_BURST_EN
      // BURST_LEN=3 latched at start; mid-run change to 1 must not matter
      run_steps(8'd3, 8'd1, 5, 24);
      apply('{1'b0,1'b0,1'b0,1'b0,8'h00,8'd1, 4'h0,8'h00,1'b0,1'b1});
      apply('{1'b0,1'b0,1'b0,1'b0,8'h00,8'd1, 4'h0,8'h00,1'b0,1'b0});
      // BURST_LEN=0 runs unbounded until STOP
      run_steps(8'd0, 8'd0, 0, 40);
      apply('{1'b0,1'b0,1'b1,1'b0,8'h00,8'd0, 4'h0,8'h00,1'b0,1'b1});
`else
      // BURST_LEN is ignored: the run keeps going past three rounds
      run_steps(8'd3, 8'd3, 0, 40);
      apply('{1'b0,1'b0,1'b1,1'b0,8'h00,8'd3, 4'h0,8'h00,1'b0,1'b1});
`endif
      apply('{1'b0,1'b0,1'b0,1'b0,8'h00,8'd0, 4'h0,8'h00,1'b0,1'b0});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/siso_seq.md
SISO_SEQ -- requirements
Module: siso_seq

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: CLK is the clock and RESET is the active-high synchronous reset.
REQ-002 The ports SHALL be, in order:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- START  in  1  run request, level-sampled.
- STOP  in  1  stop request, level-sampled.
- SHOW_LFSR  in  1  BYTE_OUT select, 1 = LFSR_STATE.
- LFSR_STATE  in  8  LFSR8 state byte.
- BURST_LEN  in  8  number of 8-step rounds per run; 0 = unbounded.
- JOHNSON  out  4  Johnson phase counter.
- PULSES  out  8  one-hot latch strobes for the 8 SISO stages.
- BUSY  out  1  high while in RUN or DRAIN.
- DONE  out  1  one-cycle end-of-run pulse.
- BYTE_OUT  out  8  byte sent to uio_out.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-004 IDLE SHALL hold JOHNSON=0000 and PULSES=0; START=1 with STOP=0 SHALL move IDLE->RUN; START and STOP both high SHALL leave the FSM in IDLE (STOP wins).
REQ-005 In RUN and DRAIN, JOHNSON SHALL advance every cycle in this order, wrapping: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 (steps 0..7).
REQ-006 PULSES SHALL be registered, aligned with JOHNSON: PULSES[k]=1 exactly when the FSM is not in IDLE and JOHNSON is at step k; otherwise 0.
REQ-007 Latency: START sampled at edge n SHALL give RUN, step 0 and PULSES=0x01 in cycle n+1, and step 7 (PULSES=0x80) in cycle n+8.
REQ-008 START sampled in RUN or DRAIN SHALL be ignored.
REQ-009 STOP sampled in RUN at step s<7 SHALL move RUN->DRAIN; DRAIN SHALL continue stepping through step 7 and then enter IDLE.
REQ-010 STOP sampled in RUN at step 7 SHALL move RUN->IDLE directly; no partial round is ever emitted.
REQ-011 STOP sampled in DRAIN SHALL be ignored.
REQ-012 DONE SHALL be high for exactly the first IDLE cycle after any RUN/DRAIN exit; otherwise 0.
REQ-013 BUSY SHALL equal (state != IDLE), registered.
REQ-014 BYTE_OUT SHALL be combinational: LFSR_STATE when SHOW_LFSR=1, else PULSES.

Reset
REQ-015 RESET=1 at a rising edge SHALL override all other inputs, including mid-round.
REQ-016 After reset: state=IDLE, JOHNSON=0000, PULSES=0x00, BUSY=0, DONE=0, round counter=0, latched burst length=0.
REQ-017 Leaving reset SHALL NOT produce a DONE pulse.

Configuration
REQ-018 Macro SISO_SEQ_BURST_EN SHALL compile the burst feature in or out.
REQ-019 With SISO_SEQ_BURST_EN defined:
- BURST_LEN SHALL be latched on the IDLE->RUN transition.
- An 8-bit round counter SHALL increment at each step 7.
- When a step 7 completes round number BURST_LEN (BURST_LEN != 0), the next state SHALL be IDLE.
- STOP SHALL keep precedence per REQ-009/010.
REQ-020 Without SISO_SEQ_BURST_EN: BURST_LEN SHALL be ignored, with no counter logic; runs SHALL end only via STOP or RESET.

Structure
REQ-021 Shared package siso_pkg SHALL hold:
- The FSM state enum (IDLE, RUN, DRAIN).
- The eight Johnson step constants.
- The stage-count constant NSTAGES=8.
REQ-022 Johnson counting and decode SHALL be a sub-module johnson4 with CLK, RESET, EN, CLR inputs and JOHNSON, ONEHOT outputs; siso_seq SHALL instantiate it once.

Verification
REQ-023 Reset with START=1 held -> PULSES=0x00, JOHNSON=0000, BUSY=0, DONE=0 during reset and in the first cycle after it; RUN begins the following cycle.
REQ-024 START pulse, STOP=0, unbounded -> PULSES 0x01,0x02,...,0x80,0x01 repeating; JOHNSON follows REQ-005; BUSY=1 from cycle n+1.
REQ-025 STOP pulse at step 3 -> steps 4..7 still emitted (0x10..0x80), then IDLE with PULSES=0x00 and DONE=1 for one cycle.
REQ-026 STOP and START both high in IDLE -> no state change, BUSY stays 0; STOP held at step 7 -> immediate IDLE, DONE=1.
REQ-027 With SISO_SEQ_BURST_EN, BURST_LEN=3 -> exactly 24 pulse cycles, then DONE; changing BURST_LEN mid-run has no effect; BURST_LEN=0 -> unbounded.
REQ-028 SHOW_LFSR toggled with LFSR_STATE=0xA5 -> BYTE_OUT=0xA5 in the same cycle; SHOW_LFSR=0 -> BYTE_OUT=PULSES; RESET mid-round at step 5 -> next cycle is IDLE, no DONE.
